mem_stage: RTL
==============

# mem_stage

MEM-stage block of the 5-stage MIPS datapath: decodes the M-stage instruction, performs data-memory stores with byte enables and delivers the raw, word-aligned read word plus low address bits to the MEM/WB register. Load sign/zero extension stays in WB. After reset, the block sweeps data memory to zero and holds a busy flag so the hazard unit can stall the pipeline.

## Interface
- ADDR_WIDTH, 10: word-address width; memory depth is 2**ADDR_WIDTH 32-bit words (4 KB).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- instrM  input  32  M-stage instruction; opcode is instrM[31:26].
- ALUOutM  input  32  effective byte address.
- WriteDataM  input  32  store data, rt value after forwarding.
- ReadDataM  output  32  raw word at ALUOutM[ADDR_WIDTH+1:2]; feeds MEM/WB.
- MemAddrM  output  2  ALUOutM[1:0], passed on for WB byte/half selection.
- MemBusyM  output  1  high while the clear sweep runs; hazard unit stalls F/D/E/M.
- AlignErrM  output  1  combinational; high when a store in M is misaligned.

## Operation
- Store opcodes: sw 6'b101011, sh 6'b101001, sb 6'b101000. All other opcodes never write.
- Byte order is little-endian. Byte k of the word is bits [8k+7:8k].
- sw: byte enable 4'b1111, data WriteDataM. Legal only when ALUOutM[1:0]==0.
- sh: byte enable 4'b0011 if ALUOutM[1]==0, else 4'b1100. Data {2{WriteDataM[15:0]}}. Legal only when ALUOutM[0]==0.
- sb: byte enable 4'b0001<<ALUOutM[1:0], data {4{WriteDataM[7:0]}}.
- Misaligned sw or sh: AlignErrM=1 and the write is suppressed. Memory is unchanged.
- Address bits above ADDR_WIDTH+1 are ignored. Addresses alias modulo 4 KB.
- FSM has two states.
  - CLEAR (entered on reset): each cycle, word clr_cnt is written with 0, then clr_cnt increments. When clr_cnt reaches 2**ADDR_WIDTH-1, that word is written and the FSM moves to IDLE.
  - IDLE: normal operation. It stays in IDLE until the next reset.
- In CLEAR:
  - MemBusyM=1.
  - Pipeline stores are ignored.
  - ReadDataM is forced to 32'h0.

## Timing
- Reset values:
  - FSM=CLEAR, clr_cnt=0, MemBusyM=1.
  - ReadDataM=0, since it is forced while in CLEAR.
  - MemAddrM and AlignErrM follow their inputs combinationally.
- The clear sweep takes exactly 2**ADDR_WIDTH cycles after rst deasserts (1024 by default).
  - MemBusyM falls on the edge that writes the last word.
  - The first normal store commits one edge later.
- Read is combinational, with zero latency. ReadDataM is valid in the same cycle as ALUOutM and is captured by MEM/WB on the next edge.
- Store commits on the rising edge that ends its M cycle.
- Same-cycle read and write to one address: ReadDataM shows the old word. The new word is visible from the next cycle.
- Back-to-back store then load to the same word: the load sees the stored data; no forwarding is needed.
- Reset asserted mid-sweep: FSM returns to CLEAR and clr_cnt to 0 immediately. The full sweep restarts.
- A store stalled in M by MemBusyM is held upstream and commits once in the first IDLE cycle. It must not be committed twice.

## Structure
- Package mips_pkg holds:
  - the opcode localparams (OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU), shared with decode and WB;
  - the FSM state encoding.
- One sub-module, dm_ram, is natural. It contains the 2**ADDR_WIDTH x 32 array, a 4-bit byte-enable synchronous write and an asynchronous read.
- mem_stage holds store decode, the alignment check, the clear FSM/counter, and the write-port mux (clear versus pipeline).

## Test plan
- Reset sweep: pulse rst, then release. MemBusyM stays 1 for exactly 1024 cycles then falls. lw from 0x0, 0x7FC and 0xFFC then returns 32'h0.
- sw/lw: sw 32'hDEADBEEF to 0x10, then lw 0x10 the next cycle. ReadDataM=32'hDEADBEEF, MemAddrM=2'b00.
- Partial stores: start with word 0x20=0. sb 8'hAA to 0x22, then sh 16'h1234 to 0x20. Word reads 32'h00AA1234; MemAddrM=2'b10 for lb 0x22.
- Misalignment: sw to 0x31 and sh to 0x33. AlignErrM=1 each cycle, and word 0x30 is still 0.
- Store during busy: sw 32'hFFFFFFFF to 0x40 at cycle 5 of the sweep. After the sweep, word 0x40=0.
- Reset mid-sweep: assert rst at sweep cycle 500. MemBusyM stays high for another full 1024 cycles after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory-access opcodes and the MEM-stage clear FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dm_ram.sv
// Data memory: 32-bit words, byte-enable synchronous write, asynchronous read.
module dm_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we && be[k]) begin
        r_mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: store decode with alignment check, post-reset memory clear sweep,
// and raw word read toward MEM/WB (extension of loads happens in WB).
//
// state    | meaning
// ST_CLEAR | writing zero to word r_clr_cnt each cycle; busy, pipeline stores ignored
// ST_IDLE  | normal load/store operation until the next reset
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [1:0]  MemAddrM,
  output logic        MemBusyM,
  output logic        AlignErrM
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  mem_state_t            r_state;
  mem_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;

  logic [5:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [3:0]            w_st_be;
  logic [31:0]           w_st_data;
  logic                  w_misalign;
  logic                  w_st_ok;

  logic                  w_ram_we;
  logic [3:0]            w_ram_be;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_ram_rdata;

  logic                  w_unused;

  assign w_op        = instrM[31:26];
  assign w_word_addr = ALUOutM[ADDR_WIDTH+1:2];
  assign w_unused    = ^{instrM[25:0], ALUOutM[31:ADDR_WIDTH+2]};

  always_comb begin
    w_st_be    = 4'b0000;
    w_st_data  = WriteDataM;
    w_misalign = 1'b0;
    unique case (w_op)
      OP_SW: begin
        w_st_be    = 4'b1111;
        w_misalign = (ALUOutM[1:0] != 2'b00);
      end
      OP_SH: begin
        w_st_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        w_st_data  = {2{WriteDataM[15:0]}};
        w_misalign = ALUOutM[0];
      end
      OP_SB: begin
        w_st_be   = 4'b0001 << ALUOutM[1:0];
        w_st_data = {4{WriteDataM[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_st_ok   = (w_st_be != 4'b0000) && !w_misalign;
  assign AlignErrM = w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR: if (r_clr_cnt == CLR_LAST) w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign MemBusyM = (r_state == ST_CLEAR);

  // The clear sweep owns the write port outright while busy.
  always_comb begin
    if (MemBusyM) begin
      w_ram_we    = 1'b1;
      w_ram_be    = 4'b1111;
      w_ram_waddr = r_clr_cnt;
      w_ram_wdata = 32'h0;
    end else begin
      w_ram_we    = w_st_ok;
      w_ram_be    = w_st_be;
      w_ram_waddr = w_word_addr;
      w_ram_wdata = w_st_data;
    end
  end

  dm_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dm_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .be   (w_ram_be),
    .waddr(w_ram_waddr),
    .wdata(w_ram_wdata),
    .raddr(w_word_addr),
    .rdata(w_ram_rdata)
  );

  assign ReadDataM = MemBusyM ? 32'h0 : w_ram_rdata;
  assign MemAddrM  = ALUOutM[1:0];

endmodule
